// File: rtl/measure_capture_if.sv
// measure_capture_if: bundles the strobe, ADC, configuration and result
// signals of measure_capture. Clock and reset stay outside the interface.
//   master : sequencer/host side (drives strobes, ADC data, config)
//   slave  : measure_capture side (drives levels, results, statistics)
interface measure_capture_if #(
   parameter int ADC_W = 14
);
   logic              verify_trigger;
   logic              trigger;
   logic [ADC_W-1:0]  adc_data;
   logic              adc_valid;
   logic [31:0]       settle_dur;
   logic [ADC_W-1:0]  threshold;
   logic              clear_stats;
   logic [ADC_W-1:0]  ref_level;
   logic [ADC_W-1:0]  meas_level;
   logic              result_valid;
   logic              switched;
   logic              missing_ref;
   logic [31:0]       total_count;
   logic [31:0]       switch_count;
   logic              busy;
   logic              overrun;

   modport master (
      output verify_trigger, trigger, adc_data, adc_valid, settle_dur,
             threshold, clear_stats,
      input  ref_level, meas_level, result_valid, switched, missing_ref,
             total_count, switch_count, busy, overrun
   );

   modport slave (
      input  verify_trigger, trigger, adc_data, adc_valid, settle_dur,
             threshold, clear_stats,
      output ref_level, meas_level, result_valid, switched, missing_ref,
             total_count, switch_count, busy, overrun
   );
endinterface

// File: rtl/measure_capture.sv
// measure_capture: after a verify_trigger (reference) or trigger (post-write)
// strobe, waits settle_dur cycles, averages 2^ACC_LOG2 ADC samples and stores
// the result as ref_level or meas_level. A post-write measurement with a
// reference held is compared against threshold and counted.
//
// Ports:
//   clk_in, rst_in          clock, asynchronous active-high reset
//   bus (slave modport)     strobes, ADC samples, settle/threshold config,
//                           clear_stats in; levels, result strobes,
//                           statistics, busy and overrun out
//
// Build option: define MEAS_SIGNED_EN to treat samples and levels as two's
// complement (threshold stays non-negative). Default is unsigned.
//
// state  | meaning
// IDLE   | waiting for a strobe
// SETTLE | counting settle cycles before sampling
// ACQ    | accumulating valid ADC samples
// DONE   | averaging, storing level, comparing and counting
module measure_capture #(
   parameter int ADC_W    = 14,
   parameter int ACC_LOG2 = 4,
   parameter int DLY_W    = 22
) (
   input  logic             clk_in,
   input  logic             rst_in,
   measure_capture_if.slave bus
);

   localparam int ACC_W = ADC_W + ACC_LOG2;
   localparam int CNT_W = ACC_LOG2 + 1;
   localparam logic [CNT_W-1:0] LAST_SAMPLE = CNT_W'((1 << ACC_LOG2) - 1);
   localparam logic [ADC_W:0]   DIFF_ONE    = {{ADC_W{1'b0}}, 1'b1};

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_SETTLE = 2'd1;
   localparam logic [1:0] S_ACQ    = 2'd2;
   localparam logic [1:0] S_DONE   = 2'd3;

   localparam logic SLOT_REF  = 1'b0;
   localparam logic SLOT_MEAS = 1'b1;

   logic [1:0]       state;
   logic             slot;
   logic [DLY_W-1:0] settle_cnt;
   logic [ACC_W-1:0] acc;
   logic [CNT_W-1:0] sample_cnt;
   logic             ref_held;

   logic [ADC_W-1:0] ref_level_q;
   logic [ADC_W-1:0] meas_level_q;
   logic             result_valid_q;
   logic             switched_q;
   logic             missing_ref_q;
   logic [31:0]      total_q;
   logic [31:0]      switch_q;
   logic             overrun_q;

   logic [ACC_W-1:0] adc_ext;
   logic [ADC_W-1:0] avg;
   logic [ADC_W:0]   avg_x;
   logic [ADC_W:0]   ref_x;
   logic [ADC_W:0]   diff;
   logic [ADC_W:0]   diff_mag;
   logic             is_switch;
   logic             compare_now;
   logic             overrun_set;
   logic             settle_unused;

   assign settle_unused = &{1'b0, bus.settle_dur[31:DLY_W]};

   // Truncating the arithmetic shift back to ADC_W bits is the same bit slice
   // in both builds; only the extension of samples and levels differs.
   assign avg = acc[ACC_LOG2 +: ADC_W];

`ifdef MEAS_SIGNED_EN
   assign adc_ext = {{ACC_LOG2{bus.adc_data[ADC_W-1]}}, bus.adc_data};
   assign avg_x   = {avg[ADC_W-1], avg};
   assign ref_x   = {ref_level_q[ADC_W-1], ref_level_q};
`else
   assign adc_ext = {{ACC_LOG2{1'b0}}, bus.adc_data};
   assign avg_x   = {1'b0, avg};
   assign ref_x   = {1'b0, ref_level_q};
`endif

   // One extra bit holds any difference of two ADC_W-bit values, so the
   // magnitude never wraps.
   always_comb begin
      diff     = avg_x - ref_x;
      diff_mag = diff;
      if (diff[ADC_W]) begin
         diff_mag = (~diff) + DIFF_ONE;
      end
   end

   assign is_switch   = diff_mag > {1'b0, bus.threshold};
   assign compare_now = (state == S_DONE) && (slot == SLOT_MEAS) && ref_held;

   // DONE counts as busy, so a strobe in the cycle busy falls is dropped too.
   assign overrun_set = (state != S_IDLE) ?
                        (bus.verify_trigger | bus.trigger) :
                        (bus.verify_trigger & bus.trigger);

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state          <= S_IDLE;
         slot           <= SLOT_REF;
         settle_cnt     <= '0;
         acc            <= '0;
         sample_cnt     <= '0;
         ref_held       <= 1'b0;
         ref_level_q    <= '0;
         meas_level_q   <= '0;
         result_valid_q <= 1'b0;
         switched_q     <= 1'b0;
         missing_ref_q  <= 1'b0;
      end else begin
         result_valid_q <= 1'b0;
         missing_ref_q  <= 1'b0;
         case (state)
            S_IDLE: begin
               if (bus.verify_trigger || bus.trigger) begin
                  slot       <= bus.verify_trigger ? SLOT_REF : SLOT_MEAS;
                  state      <= S_SETTLE;
                  settle_cnt <= '0;
                  acc        <= '0;
                  sample_cnt <= '0;
               end
            end
            S_SETTLE: begin
               if (settle_cnt == bus.settle_dur[DLY_W-1:0]) begin
                  state <= S_ACQ;
               end else begin
                  settle_cnt <= settle_cnt + DLY_W'(1);
               end
            end
            S_ACQ: begin
               if (bus.adc_valid) begin
                  acc        <= acc + adc_ext;
                  sample_cnt <= sample_cnt + CNT_W'(1);
                  if (sample_cnt == LAST_SAMPLE) begin
                     state <= S_DONE;
                  end
               end
            end
            default: begin
               state <= S_IDLE;
               if (slot == SLOT_REF) begin
                  ref_level_q <= avg;
                  ref_held    <= 1'b1;
               end else begin
                  meas_level_q <= avg;
                  if (ref_held) begin
                     switched_q     <= is_switch;
                     result_valid_q <= 1'b1;
                     ref_held       <= 1'b0;
                  end else begin
                     missing_ref_q <= 1'b1;
                  end
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         total_q   <= '0;
         switch_q  <= '0;
         overrun_q <= 1'b0;
      end else if (bus.clear_stats) begin
         total_q   <= '0;
         switch_q  <= '0;
         overrun_q <= 1'b0;
      end else begin
         if (overrun_set) begin
            overrun_q <= 1'b1;
         end
         if (compare_now) begin
            if (total_q != '1) begin
               total_q <= total_q + 32'd1;
            end
            if (is_switch && (switch_q != '1)) begin
               switch_q <= switch_q + 32'd1;
            end
         end
      end
   end

   assign bus.ref_level    = ref_level_q;
   assign bus.meas_level   = meas_level_q;
   assign bus.result_valid = result_valid_q;
   assign bus.switched     = switched_q;
   assign bus.missing_ref  = missing_ref_q;
   assign bus.total_count  = total_q;
   assign bus.switch_count = switch_q;
   assign bus.busy         = (state != S_IDLE);
   assign bus.overrun      = overrun_q;

endmodule
